msg_tx_arbiter: RTL and testbench

MSG_TX_ARBITER -- requirements
Module: msg_tx_arbiter

---
 rtl/msg_defs_pkg.sv | 33 +++
 rtl/msg_fifo.sv | 50 +++++
 rtl/msg_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_msg_tx_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_defs_pkg.sv
// Shared message definitions: IDs, word layout and status-word builder.
package msg_defs;

  localparam int MSG_W  = 32;
  localparam int ID_W   = 4;
  localparam int DATA_W = 28;

  typedef enum logic [ID_W-1:0] {
    ID_Nop      = 4'd0,
    ID_Ack      = 4'd1,
    ID_Pll      = 4'd2,
    ID_ADC      = 4'd3,
    ID_Ldo      = 4'd4,
    ID_Temp     = 4'd5,
    ID_Volt     = 4'd6,
    ID_Curr     = 4'd7,
    ID_Cfg      = 4'd8,
    ID_Err      = 4'd9,
    ID_Rsv10    = 4'd10,
    ID_Rsv11    = 4'd11,
    ID_Rsv12    = 4'd12,
    ID_Rsv13    = 4'd13,
    ID_Rsv14    = 4'd14,
    ID_PowerOff = 4'd15
  } msg_id_e;

  localparam logic [3:0] STATUS_FLAG = 4'h8;

  function automatic logic [MSG_W-1:0] status_word(input logic [4:0] occ);
    return {ID_Nop, STATUS_FLAG, 19'b0, occ};
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous word FIFO with head output, full/empty flags and occupancy count.
module msg_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/msg_tx_arbiter.sv
// Arbitrates N message sources plus host status words into one TX FIFO.
// Define MSG_ARB_RR_EN for round-robin; default build is fixed priority.
module msg_tx_arbiter
  import msg_defs::*;
#(
  parameter int N_SRC      = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [ID_W*N_SRC-1:0]   src_id,
  input  logic [DATA_W*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  input  logic                    cnt_req,
  output logic [MSG_W-1:0]        tx_word,
  output logic                    tx_valid,
  input  logic                    tx_take,
  output logic                    irq
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic             cnt_s1, cnt_s2, cnt_prev, cnt_edge;
  logic [1:0]       blank_cnt;
  logic             status_pend, status_push;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CW-1:0]    fifo_count;
  logic [MSG_W-1:0] fifo_head, fifo_wdata;
  logic             src_space, found, src_push;
  logic [PTR_W-1:0] grant_idx;
  logic [N_SRC-1:0] grant;

  // blank_cnt masks the edge produced when a high cnt_req level flushes
  // through the freshly reset sync chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s1    <= 1'b0;
      cnt_s2    <= 1'b0;
      cnt_prev  <= 1'b0;
      blank_cnt <= 2'd3;
    end else begin
      cnt_s1   <= cnt_req;
      cnt_s2   <= cnt_s1;
      cnt_prev <= cnt_s2;
      if (blank_cnt != 2'd0) blank_cnt <= blank_cnt - 2'd1;
    end
  end

  assign cnt_edge = (cnt_s2 ^ cnt_prev) && (blank_cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_pend <= 1'b0;
    else        status_pend <= cnt_edge || (status_pend && !status_push);
  end

  // Status only enters on real space; while pending it also blocks sources
  assign fifo_pop    = tx_take && !fifo_empty;
  assign status_push = status_pend && !fifo_full;
  assign src_space   = rst_n && !status_pend && (!fifo_full || fifo_pop);

`ifdef MSG_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_ptr <= '0;
    else if (src_push) rr_ptr <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_valid[(int'(rr_ptr) + k) % N_SRC]) begin
        found     = 1'b1;
        grant_idx = PTR_W'((int'(rr_ptr) + k) % N_SRC);
      end
    end
  end
`else
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_valid[k]) begin
        found     = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (found && src_space) grant[grant_idx] = 1'b1;
  end

  assign src_ready  = grant;
  assign src_push   = |grant;
  assign fifo_push  = status_push || src_push;
  assign fifo_wdata = status_push ? status_word(5'(fifo_count))
                                  : {src_id[grant_idx*ID_W +: ID_W],
                                     src_data[grant_idx*DATA_W +: DATA_W]};

  msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MSG_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign tx_word  = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= !fifo_empty;
  end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Directed bench for msg_tx_arbiter: vector table plus multi-cycle sequences.
module tb_msg_tx_arbiter;
  import msg_defs::*;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst_n, cnt_req, tx_take, tx_valid, irq;
  logic [N-1:0]   src_valid, src_ready;
  logic [4*N-1:0] src_id;
  logic [28*N-1:0] src_data;
  logic [31:0]    tx_word;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  valid;
    logic        take;
    logic [5:0]  ready;
    logic        tv;
    logic        irq;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs [10];
  logic [5:0]  exp_ord [4];
  logic [31:0] exp_w [4];

  always #5 clk = ~clk;

  msg_tx_arbiter #(.N_SRC(N), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_id    (src_id),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cnt_req   (cnt_req),
    .tx_word   (tx_word),
    .tx_valid  (tx_valid),
    .tx_take   (tx_take),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [3:0] id, input logic [27:0] d);
    src_id[i*4 +: 4]    = id;
    src_data[i*28 +: 28] = d;
  endtask

  initial begin
    vecs[0] = '{6'b000100, 1'b0, 6'b000100, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 1'b0, 32'h3002_0005};
    vecs[2] = '{6'b000000, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h3002_0005};
    vecs[3] = '{6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{6'b100000, 1'b1, 6'b100000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[5] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{6'b000010, 1'b1, 6'b000010, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h2111_1111};
    vecs[8] = '{6'b000000, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h2111_1111};
    vecs[9] = '{6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1, 32'h0000_0000};
`ifdef MSG_ARB_RR_EN
    exp_ord = '{6'b000001, 6'b000010, 6'b000100, 6'b000001};
    exp_w   = '{32'h1000_00A0, 32'h2111_1111, 32'h3002_0005, 32'h1000_00A0};
`else
    exp_ord = '{6'b000001, 6'b000001, 6'b000001, 6'b000001};
    exp_w   = '{32'h1000_00A0, 32'h1000_00A0, 32'h1000_00A0, 32'h1000_00A0};
`endif

    rst_n     = 1'b0;
    cnt_req   = 1'b1;
    tx_take   = 1'b0;
    src_valid = 6'b000001;
    src_id    = '0;
    src_data  = '0;
    set_src(0, 4'h1, 28'h00000A0);
    set_src(1, 4'h2, 28'h1111111);
    set_src(2, ID_ADC, 28'h0020005);
    set_src(3, 4'h4, 28'h0000033);
    set_src(4, 4'h5, 28'h0000044);
    set_src(5, ID_PowerOff, 28'hFFFFFFF);

    // reset state, then cnt_req held high across release
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_ready", 32'(src_ready), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tx_word", tx_word, 32'h0);
    src_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("blank_tx_valid", 32'(tx_valid), 32'h0);
      check("blank_tx_word", tx_word, 32'h0);
      check("blank_irq", 32'(irq), 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      src_valid = vecs[i].valid;
      tx_take   = vecs[i].take;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(src_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].tv));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
      check($sformatf("vec%0d_tx_word", i), tx_word, vecs[i].word);
      tick();
    end
    src_valid = '0;
    tx_take   = 1'b0;

    // arbitration order from a fresh pointer
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      src_valid = 6'b000111;
      #1;
      check($sformatf("arb_grant%0d", c), 32'(src_ready), 32'(exp_ord[c]));
      tick();
    end
    src_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tx_take = 1'b1;
      #1;
      check($sformatf("arb_word%0d", c), tx_word, exp_w[c]);
      tick();
    end
    tx_take = 1'b0;
    #1;
    check("arb_drained", 32'(tx_valid), 32'h0);
    tick();

    // status word after three queued data words
    src_valid = 6'b001000;
    repeat (3) tick();
    src_valid = '0;
    cnt_req   = 1'b0;
    repeat (8) tick();
    for (int c = 0; c < 4; c++) begin
      tx_take = 1'b1;
      #1;
      check($sformatf("stat3_word%0d", c), tx_word, (c < 3) ? 32'h4000_0033 : 32'h0800_0003);
      tick();
    end
    tx_take = 1'b0;
    #1;
    check("stat3_single", 32'(tx_valid), 32'h0);
    tick();

    // full FIFO, two toggles merge into one status word with occ=7
    src_valid = 6'b010000;
    repeat (8) tick();
    #1;
    check("full_ready_low", 32'(src_ready), 32'h0);
    check("full_tx_valid", 32'(tx_valid), 32'h1);
    src_valid = '0;
    cnt_req   = 1'b1;
    repeat (3) tick();
    cnt_req   = 1'b0;
    repeat (8) tick();
    for (int c = 0; c < 9; c++) begin
      tx_take = 1'b1;
      #1;
      check($sformatf("full_word%0d", c), tx_word, (c < 8) ? 32'h5000_0044 : 32'h0800_0007);
      tick();
    end
    tx_take = 1'b0;
    #1;
    check("full_empty", 32'(tx_valid), 32'h0);
    repeat (3) tick();
    check("full_one_status", 32'(tx_valid), 32'h0);

    // asynchronous reset with words queued
    tick();
    src_valid = 6'b100000;
    repeat (5) tick();
    src_valid = '0;
    #1;
    check("mid_pre_valid", 32'(tx_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(tx_valid), 32'h0);
    check("mid_async_word", tx_word, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("mid_no_stale", 32'(tx_valid), 32'h0);
    src_valid = 6'b000001;
    #1;
    check("mid_new_grant", 32'(src_ready), 32'h1);
    tick();
    src_valid = '0;
    #1;
    check("mid_new_word", tx_word, 32'h1000_00A0);
    check("mid_new_irq", 32'(irq), 32'h0);
    tick();
    check("mid_new_irq_set", 32'(irq), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
